inv_mix_columns_seq: RTL and testbench
======================================

INV_MIX_COLUMNS_SEQ -- requirements
Module: inv_mix_columns_seq

Interface
REQ-001 SHALL expose: clk  input  1  rising-edge clock; the block uses one clock only.
REQ-002 SHALL expose: rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL expose: enableInvMixColumns  input  1  start request; sampled only in IDLE.
REQ-004 SHALL expose: state  input  128  ciphertext-side state, [0:127] ordering; byte k = bits [8k:8k+7]; column c = bytes 4c..4c+3.
REQ-005 SHALL expose: stateOut  output  128  InvMixColumns result, same ordering, registered.
REQ-006 SHALL expose: busy  output  1  high while a transform is in progress.
REQ-007 SHALL expose: invMixColumnsDone  output  1  one-cycle pulse marking stateOut valid.

Function
REQ-008 SHALL compute each output column as b0=0e*a0^0b*a1^0d*a2^09*a3, b1=09*a0^0e*a1^0b*a2^0d*a3, b2=0d*a0^09*a1^0e*a2^0b*a3, b3=0b*a0^0d*a1^09*a2^0e*a3 in GF(2^8) mod 0x11B.
REQ-009 SHALL implement the GF multiplies with xtime chains, using no lookup tables; all intermediates are 8 bits.
REQ-010 SHALL implement an FSM with states IDLE and BUSY, plus a 2-bit column counter colCnt.
REQ-011 SHALL, in IDLE with enableInvMixColumns=1 at a rising edge, capture state into an internal register, clear colCnt, set busy=1 and enter BUSY.
REQ-012 SHALL, at each BUSY edge, write column colCnt of stateOut from the captured register and increment colCnt.
REQ-013 SHALL, at the BUSY edge with colCnt=3, write column 3, pulse invMixColumnsDone=1 for exactly one cycle, clear busy and return to IDLE.
REQ-014 SHALL produce invMixColumnsDone 4 cycles after the start-accepting edge.
REQ-015 SHALL ignore enableInvMixColumns while BUSY, and changes on state after capture SHALL NOT affect the result.
REQ-016 SHALL accept a start in the same cycle that invMixColumnsDone is high, giving back-to-back operation with no idle gap.
REQ-017 SHALL hold stateOut unchanged in IDLE; partially written stateOut during BUSY is undefined for consumers.
REQ-018 SHALL respond to a level-held start by starting a new transform at each IDLE edge where it is high.

Reset
REQ-019 SHALL, on rst=1 at any time including mid-transform, immediately clear stateOut to 0, busy, invMixColumnsDone and colCnt, and set the FSM to IDLE.
REQ-020 SHALL discard an aborted transform, SHALL NOT pulse done for it, and SHALL NOT accept a start while rst=1.

Configuration
REQ-021 SHALL support the macro INV_MIX_COLUMNS_PARALLEL_EN.
REQ-022 SHALL, when INV_MIX_COLUMNS_PARALLEL_EN is defined, instantiate four column units, have BUSY last one cycle, write all columns at once, and pulse done 1 cycle after start.
REQ-023 SHALL, when INV_MIX_COLUMNS_PARALLEL_EN is undefined, use one shared column unit with 4-cycle latency per REQ-014; port list and handshake are identical in both builds.

Structure
REQ-024 SHALL place in the shared package aes_pkg: the FSM state typedef, AES_POLY=8'h1B, the column count 4 and the byte width 8.
REQ-025 SHALL use one combinational sub-module, inv_mix_column_word (32-bit column in, 32-bit column out), instantiated once in serial builds and four times in parallel builds.

Verification
REQ-026 SHALL test a FIPS-197 column: column 0 = 04 66 81 e5, others 0, start pulse -> column 0 = d4 bf 5d 30, others 0, done pulse at start+4.
REQ-027 SHALL test a full state 8e4da1bc_9fdc589d_01010101_d5d5d7d6 -> db135345_f20a225c_01010101_d4d4d4d5, with busy high for exactly 4 cycles.
REQ-028 SHALL test back-to-back operation: second start (state all c6) asserted in the done cycle -> second done 4 cycles later, stateOut all c6.
REQ-029 SHALL test start ignored while BUSY: start pulsed at start+2 with a new state -> exactly one done, result from the first state only.
REQ-030 SHALL test reset mid-operation: rst asserted at start+2 -> stateOut=0, busy=0, no done; next start yields a correct result.
REQ-031 SHALL test the parallel build with INV_MIX_COLUMNS_PARALLEL_EN defined: REQ-027 vector -> same result, done at start+1.

Source files
------------

// File: rtl/aes_pkg.sv
// ============================================================================
// Module      : aes_pkg
// Description : Shared AES types, constants and the GF(2^8) xtime helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package aes_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } fsm_state_t;

    localparam logic [7:0] AES_POLY = 8'h1B;
    localparam int         NUM_COLS = 4;
    localparam int         BYTE_W   = 8;

    // Multiply by x in GF(2^8), reduced modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [BYTE_W-1:0] xtime(input logic [BYTE_W-1:0] a);
        return {a[BYTE_W-2:0], 1'b0} ^ (a[BYTE_W-1] ? AES_POLY : 8'h00);
    endfunction

endpackage

`default_nettype wire

// File: rtl/inv_mix_column_word.sv
// ============================================================================
// Module      : inv_mix_column_word
// Description : Combinational InvMixColumns on one 32-bit column (a0 = MSB).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module inv_mix_column_word
    import aes_pkg::*;
(
    input  logic [31:0] col_in,
    output logic [31:0] col_out
);

    logic [BYTE_W-1:0] a   [NUM_COLS];
    logic [BYTE_W-1:0] x2  [NUM_COLS];
    logic [BYTE_W-1:0] x4  [NUM_COLS];
    logic [BYTE_W-1:0] x8  [NUM_COLS];
    logic [BYTE_W-1:0] m09 [NUM_COLS];
    logic [BYTE_W-1:0] m0b [NUM_COLS];
    logic [BYTE_W-1:0] m0d [NUM_COLS];
    logic [BYTE_W-1:0] m0e [NUM_COLS];

    genvar i;
    generate
        for (i = 0; i < NUM_COLS; i++) begin : g_byte
            assign a[i]   = col_in[31-8*i -: 8];
            assign x2[i]  = xtime(a[i]);
            assign x4[i]  = xtime(x2[i]);
            assign x8[i]  = xtime(x4[i]);
            // Constants decomposed into powers of x: 9=8+1, b=8+2+1, d=8+4+1, e=8+4+2.
            assign m09[i] = x8[i] ^ a[i];
            assign m0b[i] = x8[i] ^ x2[i] ^ a[i];
            assign m0d[i] = x8[i] ^ x4[i] ^ a[i];
            assign m0e[i] = x8[i] ^ x4[i] ^ x2[i];
        end
    endgenerate

    assign col_out = {m0e[0] ^ m0b[1] ^ m0d[2] ^ m09[3],
                      m09[0] ^ m0e[1] ^ m0b[2] ^ m0d[3],
                      m0d[0] ^ m09[1] ^ m0e[2] ^ m0b[3],
                      m0b[0] ^ m0d[1] ^ m09[2] ^ m0e[3]};

endmodule

`default_nettype wire

// File: rtl/inv_mix_columns_seq.sv
// ============================================================================
// Module      : inv_mix_columns_seq
// Description : Sequential AES InvMixColumns; one column per cycle, or all four
//               at once when INV_MIX_COLUMNS_PARALLEL_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module inv_mix_columns_seq
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         enableInvMixColumns,
    input  logic [0:127] state,
    output logic [0:127] stateOut,
    output logic         busy,
    output logic         invMixColumnsDone
);

    fsm_state_t   fsm_q;
    fsm_state_t   fsm_d;
    logic [0:127] captured;
    logic         last;

`ifdef INV_MIX_COLUMNS_PARALLEL_EN
    logic [0:127] par_out;

    genvar c;
    generate
        for (c = 0; c < NUM_COLS; c++) begin : g_col
            inv_mix_column_word u_col (
                .col_in  (captured[32*c +: 32]),
                .col_out (par_out[32*c +: 32])
            );
        end
    endgenerate

    assign last = 1'b1;
`else
    logic [1:0]  colCnt;
    logic [31:0] col_sel;
    logic [31:0] col_res;

    assign col_sel = captured[{colCnt, 5'b0} +: 32];
    assign last    = (colCnt == 2'd3);

    inv_mix_column_word u_col (
        .col_in  (col_sel),
        .col_out (col_res)
    );
`endif

    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            IDLE:    if (enableInvMixColumns) fsm_d = BUSY;
            BUSY:    if (last)                fsm_d = IDLE;
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q             <= IDLE;
            captured          <= '0;
            stateOut          <= '0;
            busy              <= 1'b0;
            invMixColumnsDone <= 1'b0;
`ifndef INV_MIX_COLUMNS_PARALLEL_EN
            colCnt            <= 2'd0;
`endif
        end else begin
            fsm_q             <= fsm_d;
            invMixColumnsDone <= 1'b0;
            if (fsm_q == IDLE) begin
                if (enableInvMixColumns) begin
                    captured <= state;
                    busy     <= 1'b1;
`ifndef INV_MIX_COLUMNS_PARALLEL_EN
                    colCnt   <= 2'd0;
`endif
                end
            end else begin
`ifdef INV_MIX_COLUMNS_PARALLEL_EN
                stateOut <= par_out;
`else
                stateOut[{colCnt, 5'b0} +: 32] <= col_res;
                colCnt                         <= colCnt + 2'd1;
`endif
                if (last) begin
                    invMixColumnsDone <= 1'b1;
                    busy              <= 1'b0;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_inv_mix_columns_seq.sv
// ============================================================================
// Module      : tb_inv_mix_columns_seq
// Description : Self-checking bench for inv_mix_columns_seq (either build).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_inv_mix_columns_seq;

`ifdef INV_MIX_COLUMNS_PARALLEL_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 4;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en  = 1'b0;
    logic [0:127] st  = '0;
    logic [0:127] stateOut;
    logic         busy;
    logic         done;

    int total = 0;
    int bad   = 0;
    bit checking = 1'b0;

    inv_mix_columns_seq dut (
        .clk                 (clk),
        .rst                 (rst),
        .enableInvMixColumns (en),
        .state               (st),
        .stateOut            (stateOut),
        .busy                (busy),
        .invMixColumnsDone   (done)
    );

    always #5 clk = ~clk;

    // Generic shift-and-add GF(2^8) multiply.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [0:127] invmix(input logic [0:127] s);
        logic [7:0]   coef [4] = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        logic [0:127] r;
        logic [7:0]   acc;
        for (int c = 0; c < 4; c++)
            for (int row = 0; row < 4; row++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++)
                    acc = acc ^ gf_mul(s[32*c + 8*j +: 8], coef[(j - row + 4) % 4]);
                r[32*c + 8*row +: 8] = acc;
            end
        return r;
    endfunction

    // Transaction-level model: a countdown to completion per accepted start.
    int           m_left    = 0;
    logic [0:127] m_pending = '0;
    logic [0:127] m_out     = '0;
    logic         m_busy    = 1'b0;
    logic         m_done    = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left <= 0; m_out <= '0; m_busy <= 1'b0; m_done <= 1'b0;
        end else if (m_left != 0) begin
            m_left <= m_left - 1;
            m_done <= (m_left == 1);
            if (m_left == 1) begin
                m_out  <= m_pending;
                m_busy <= 1'b0;
            end
        end else begin
            m_done <= 1'b0;
            if (en) begin
                m_pending <= invmix(st);
                m_left    <= LAT;
                m_busy    <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            total++;
            if (busy !== m_busy) begin
                bad++; $display("FAIL cmp_busy t=%0t: got %b expected %b", $time, busy, m_busy);
            end
            total++;
            if (done !== m_done) begin
                bad++; $display("FAIL cmp_done t=%0t: got %b expected %b", $time, done, m_done);
            end
            if (!m_busy) begin
                total++;
                if (stateOut !== m_out) begin
                    bad++; $display("FAIL cmp_out t=%0t: got %h expected %h", $time, stateOut, m_out);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [0:127] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Called at a negedge; returns at the negedge where done is seen.
    task automatic do_op(input logic [0:127] d, output int n, output int bc);
        en = 1'b1; st = d;
        @(negedge clk);
        en = 1'b0; st = rnd128();
        n = 0; bc = 0;
        while (!done && n < 20) begin
            if (busy) bc++;
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            bad++; total++;
            $display("FAIL done_timeout: got no done expected done within %0d", LAT);
        end
    endtask

    localparam logic [0:127] FIPS_IN  = 128'h046681e5_00000000_00000000_00000000;
    localparam logic [0:127] FIPS_OUT = 128'hd4bf5d30_00000000_00000000_00000000;
    localparam logic [0:127] FULL_IN  = 128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6;
    localparam logic [0:127] FULL_OUT = 128'hdb135345_f20a225c_01010101_d4d4d4d5;
    localparam logic [0:127] ALL_C6   = {16{8'hc6}};

    initial begin
        int n, bc, dones;
        logic [0:127] a, b;

        checking = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_out",  stateOut, '0);
        chk("reset_busy", {127'd0, busy}, 128'd0);
        chk("reset_done", {127'd0, done}, 128'd0);

        chk("model_fips", invmix(FIPS_IN), FIPS_OUT);
        chk("model_full", invmix(FULL_IN), FULL_OUT);
        chk("model_c6",   invmix(ALL_C6),  ALL_C6);

        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        do_op(FIPS_IN, n, bc);
        chk("fips_latency", n, LAT);
        chk("fips_out", stateOut, FIPS_OUT);

        do_op(FULL_IN, n, bc);
        chk("full_latency", n, LAT);
        chk("full_busy_cycles", bc, LAT);
        chk("full_out", stateOut, FULL_OUT);

        do_op(ALL_C6, n, bc);
        chk("b2b_latency", n, LAT);
        chk("b2b_out", stateOut, ALL_C6);

        // Start pulsed again while the first transform is running.
        a = rnd128(); b = rnd128();
        @(negedge clk);
        en = 1'b1; st = a;
        @(negedge clk);
        en = 1'b0; st = rnd128();
        if (LAT >= 3) @(negedge clk);
        en = 1'b1; st = b;
        @(negedge clk);
        en = 1'b0; st = rnd128();
        dones = (done === 1'b1) ? 1 : 0;
        repeat (10) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
        end
        chk("ignore_done_count", dones, 1);
        chk("ignore_out", stateOut, invmix(a));

        // Reset in the middle of a transform, with a start held during reset.
        en = 1'b1; st = FULL_IN;
        @(negedge clk);
        en = 1'b0;
        if (LAT >= 3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_out",  stateOut, '0);
        chk("midrst_busy", {127'd0, busy}, 128'd0);
        en = 1'b1; st = ALL_C6;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0; en = 1'b0;
        chk("rst_no_start_busy", {127'd0, busy}, 128'd0);
        dones = 0;
        repeat (8) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
        end
        chk("midrst_no_done", dones, 0);
        chk("midrst_out_held", stateOut, '0);

        do_op(FULL_IN, n, bc);
        chk("post_rst_latency", n, LAT);
        chk("post_rst_out", stateOut, FULL_OUT);

        // Random traffic: level-held starts, starts while busy, changing state.
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            en = ($urandom_range(0, 3) == 0);
            st = rnd128();
        end
        en = 1'b0;
        repeat (10) @(negedge clk);

        checking = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
